// File: rtl/mem_cont_responder.sv
// mem_cont_responder
//   Single-clock RAM model answering the MemCont load/store port. It accepts
//   one load and one store per cycle with no backpressure. Load data returns
//   after READ_LATENCY cycles through a shift-register pipeline. The block
//   counts accepted loads and performed stores, and keeps a sticky
//   out-of-range error with the address of the first offending access.
//
// Parameters
//   DATA_SIZE     data word width
//   ADDRESS_SIZE  word address width
//   DEPTH         number of words; legal addresses are 0..DEPTH-1
//   READ_LATENCY  cycles from load_en to load_data_valid (>= 1)
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   load_en/addr     read request and its address
//   load_data/valid  read result and its one-cycle strobe
//   store_en/addr/data  write request
//   load_count       loads accepted since reset (wraps)
//   store_count      in-range stores performed since reset (wraps)
//   err/err_addr     sticky out-of-range flag and address of the first offender
module mem_cont_responder #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en,
  input  logic [ADDRESS_SIZE-1:0] load_addr,
  output logic [DATA_SIZE-1:0]    load_data,
  output logic                    load_data_valid,
  input  logic                    store_en,
  input  logic [ADDRESS_SIZE-1:0] store_addr,
  input  logic [DATA_SIZE-1:0]    store_data,
  output logic [31:0]             load_count,
  output logic [31:0]             store_count,
  output logic                    err,
  output logic [ADDRESS_SIZE-1:0] err_addr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_SIZE-1:0] DEPTH_A = ADDRESS_SIZE'(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // A full-width compare also rejects addresses whose bits above the index are
  // nonzero. Those addresses would otherwise alias onto a legal word.
  logic             ld_ok, st_ok, ld_bad, st_bad;
  logic [IDX_W-1:0] ld_idx, st_idx;

  assign ld_ok  = (load_addr < DEPTH_A);
  assign st_ok  = (store_addr < DEPTH_A);
  assign ld_bad = load_en && !ld_ok;
  assign st_bad = store_en && !st_ok;
  assign ld_idx = load_addr[IDX_W-1:0];
  assign st_idx = store_addr[IDX_W-1:0];

  // NOTE: the RAM array has no reset on purpose. Contents survive rst, and a
  // resettable array would not map onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && store_en && st_ok) begin
      mem[st_idx] <= store_data;
    end
  end

  // Read pipeline. Stage 0 samples the RAM at the same edge a store may write
  // it. Non-blocking semantics make this a read-first access, so a
  // same-address load returns the old word. A data stage loads only when
  // valid data enters it, which keeps load_data steady between pulses.
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [DATA_SIZE-1:0]    pipe_data [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= load_en;
      if (load_en) begin
        pipe_data[0] <= ld_ok ? mem[ld_idx] : '0;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign load_data       = pipe_data[READ_LATENCY-1];
  assign load_data_valid = pipe_valid[READ_LATENCY-1];

  // The counters wrap silently. err_addr records only the first error. When
  // both ports are out of range in that cycle, the store address is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count  <= '0;
      store_count <= '0;
      err         <= 1'b0;
      err_addr    <= '0;
    end else begin
      if (load_en) begin
        load_count <= load_count + 32'd1;
      end
      if (store_en && st_ok) begin
        store_count <= store_count + 32'd1;
      end
      if (!err && (ld_bad || st_bad)) begin
        err      <= 1'b1;
        err_addr <= st_bad ? store_addr : load_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_cont_responder.sv
// Self-checking bench for mem_cont_responder. One instance uses
// READ_LATENCY = 1 (the MemCont setting) and a second uses READ_LATENCY = 3.
// Both receive the same stimulus. Each issued load pushes
// {due edge, expected data} into that instance's scoreboard queue. A monitor
// samples on the falling edge, pops the queue and compares whenever a result
// is due or a valid pulse appears. Counters and the error flag are compared
// directly.
module tb_mem_cont_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0, store_en = 1'b0;
  logic [31:0] load_addr = '0, store_addr = '0, store_data = '0;

  logic [31:0] d1, d3, lc1, lc3, sc1, sc3, ea1, ea3;
  logic        v1, v3, e1, e3;

  always #5 clk = ~clk;

  mem_cont_responder #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(d1), .load_data_valid(v1),
    .store_en(store_en), .store_addr(store_addr), .store_data(store_data),
    .load_count(lc1), .store_count(sc1), .err(e1), .err_addr(ea1)
  );

  mem_cont_responder #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(d3), .load_data_valid(v3),
    .store_en(store_en), .store_addr(store_addr), .store_data(store_data),
    .load_count(lc3), .store_count(sc3), .err(e3), .err_addr(ea3)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t sb [2][$];
  int   lat [2] = '{1, 3};
  int   edge_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // A load sampled at edge k is expected to be visible after edge
  // k + lat - 1.
  task automatic mon(int k, string tag, logic v, logic [31:0] d);
    if (sb[k].size() > 0 && sb[k][0].due == edge_cnt) begin
      check({tag, "_valid"}, 32'(v), 32'd1);
      check({tag, "_data"}, d, sb[k][0].data);
      void'(sb[k].pop_front());
    end else if (v === 1'b1) begin
      check({tag, "_unexpected_valid"}, 32'(v), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, "rl1", v1, d1);
    mon(1, "rl3", v3, d3);
  end

  task automatic push_load(logic [31:0] ed);
    for (int k = 0; k < 2; k++) sb[k].push_back('{edge_cnt + lat[k], ed});
  endtask

  // Drive one cycle of stimulus. The falling edge has been sampled by the
  // monitor before these inputs change.
  task automatic drive(logic le, logic [31:0] la, logic se, logic [31:0] sa,
                       logic [31:0] sd, logic [31:0] ed);
    @(negedge clk);
    #1;
    load_en = le; load_addr = la;
    store_en = se; store_addr = sa; store_data = sd;
    if (le) push_load(ed);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  // Assert rst for one edge while also presenting requests that must be
  // dropped. Results due at or after that edge are discarded.
  task automatic reset_pulse(logic le, logic [31:0] la, logic se,
                             logic [31:0] sa, logic [31:0] sd);
    @(negedge clk);
    #1;
    rst = 1'b1;
    load_en = le; load_addr = la;
    store_en = se; store_addr = sa; store_data = sd;
    for (int k = 0; k < 2; k++)
      while (sb[k].size() > 0 && sb[k][sb[k].size()-1].due >= edge_cnt + 1)
        void'(sb[k].pop_back());
    @(negedge clk);
    #1;
    rst = 1'b0;
    load_en = 1'b0; store_en = 1'b0;
    load_addr = '0; store_addr = '0; store_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("reset_load_count", lc1, 32'd0);
    check("reset_store_count", sc1, 32'd0);
    check("reset_err", 32'(e1), 32'd0);
    check("reset_err_addr", ea1, 32'd0);
    check("reset_load_data_rl3", d3, 32'd0);
    check("reset_valid_rl3", 32'(v3), 32'd0);

    // Store then load the same address on the next cycle.
    drive(1'b0, '0, 1'b1, 32'd5, 32'hDEAD_BEEF, '0);
    drive(1'b1, 32'd5, 1'b0, '0, '0, 32'hDEAD_BEEF);
    idle(4);
    check("basic_store_count", sc1, 32'd1);
    check("basic_load_count", lc1, 32'd1);

    // Read-first on a same-cycle load and store to one address.
    drive(1'b0, '0, 1'b1, 32'd3, 32'h11, '0);
    drive(1'b1, 32'd3, 1'b1, 32'd3, 32'h22, 32'h11);
    drive(1'b1, 32'd3, 1'b0, '0, '0, 32'h22);
    idle(4);

    // Back-to-back loads come out in order, one per cycle.
    drive(1'b0, '0, 1'b1, 32'd0, 32'hA0, '0);
    drive(1'b0, '0, 1'b1, 32'd1, 32'hA1, '0);
    drive(1'b0, '0, 1'b1, 32'd2, 32'hA2, '0);
    drive(1'b1, 32'd0, 1'b0, '0, '0, 32'hA0);
    drive(1'b1, 32'd1, 1'b0, '0, '0, 32'hA1);
    drive(1'b1, 32'd2, 1'b0, '0, '0, 32'hA2);
    drive(1'b1, 32'd3, 1'b0, '0, '0, 32'h22);
    idle(4);
    check("burst_store_count", sc1, 32'd6);
    check("burst_load_count_rl3", lc3, 32'd7);

    // Out-of-range accesses.
    drive(1'b0, '0, 1'b1, 32'd1024, 32'h99, '0);
    drive(1'b1, 32'd2000, 1'b0, '0, '0, 32'h0);
    idle(4);
    check("oob_err", 32'(e1), 32'd1);
    check("oob_err_addr", ea1, 32'd1024);
    check("oob_store_count", sc1, 32'd6);
    check("oob_load_count", lc1, 32'd8);
    // Upper address bits set: the access must not alias onto address 5.
    // err_addr stays sticky.
    drive(1'b1, 32'h0001_0005, 1'b1, 32'h0002_0000, 32'h77, 32'h0);
    drive(1'b0, '0, 1'b1, 32'd1023, 32'hCAFE, '0);
    drive(1'b1, 32'd1023, 1'b0, '0, '0, 32'hCAFE);
    idle(4);
    check("sticky_err_addr_rl3", ea3, 32'd1024);
    check("edge_store_count", sc1, 32'd7);
    check("edge_load_count", lc1, 32'd10);

    // Reset mid-read. The requests presented during reset are dropped, and
    // address 5 keeps 0xDEADBEEF.
    drive(1'b1, 32'd5, 1'b0, '0, '0, 32'hDEAD_BEEF);
    reset_pulse(1'b1, 32'd5, 1'b1, 32'd5, 32'h0BAD);
    check("rst_mid_load_count_rl3", lc3, 32'd0);
    check("rst_mid_store_count_rl3", sc3, 32'd0);
    check("rst_mid_err_rl3", 32'(e3), 32'd0);
    check("rst_mid_err_addr", ea1, 32'd0);
    check("rst_mid_load_data_rl1", d1, 32'd0);
    drive(1'b1, 32'd5, 1'b0, '0, '0, 32'hDEAD_BEEF);
    idle(4);
    check("post_rst_load_count", lc1, 32'd1);

    // Load counter wraps from 0xFFFFFFFF to 0 without setting err.
    @(negedge clk);
    #1;
    load_en = 1'b1; load_addr = 32'd5;
    push_load(32'hDEAD_BEEF);
    force u_dut1.load_count = 32'hFFFF_FFFF;
    #1;
    release u_dut1.load_count;
    idle(4);
    check("wrap_load_count", lc1, 32'd0);
    check("wrap_err", 32'(e1), 32'd0);
    check("wrap_load_count_rl3", lc3, 32'd2);

    idle(2);
    check("rl1_scoreboard_drained", 32'(sb[0].size()), 32'd0);
    check("rl3_scoreboard_drained", 32'(sb[1].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_cont_responder.md
# mem_cont_responder

Single-clock memory responder that sits on the far side of the MemCont load/store port and answers its requests, acting as the on-chip RAM the controller drives. Accepts one load and one store per cycle, returns load data after a fixed read latency, and tracks access counts and out-of-range errors for the testbench and the elastic-circuit debug path. Synthesises to block RAM plus a small read-data pipeline.

## Interface
- DATA_SIZE, 32, data word width
- ADDRESS_SIZE, 32, address width, word-addressed
- DEPTH, 1024, number of words; legal addresses are 0..DEPTH-1
- READ_LATENCY, 1, cycles from load_en to load_data_valid; must be >= 1; MemCont requires 1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- load_en  in  1  read request this cycle
- load_addr  in  ADDRESS_SIZE  read address
- load_data  out  DATA_SIZE  read data, valid when load_data_valid is high
- load_data_valid  out  1  read data strobe
- store_en  in  1  write request this cycle
- store_addr  in  ADDRESS_SIZE  write address
- store_data  in  DATA_SIZE  write data
- load_count  out  32  accepted loads since reset
- store_count  out  32  performed stores since reset
- err  out  1  sticky out-of-range flag
- err_addr  out  ADDRESS_SIZE  address of the first out-of-range access

## Operation
- No backpressure: every load_en and store_en cycle is accepted; no ready outputs.
- Store: store_en high and store_addr < DEPTH writes store_data to mem[store_addr] at that edge; store_count += 1.
- Load: load_en high samples load_addr; data emerges READ_LATENCY cycles later with load_data_valid high for exactly one cycle per request; load_count += 1 per request, counted at acceptance.
- Read pipeline: shift register of READ_LATENCY stages carrying valid and data; back-to-back loads every cycle are sustained, with one result per cycle in request order.
- Same-cycle load and store to the same address: read-first; load returns the pre-store contents.
- Store followed by load to the same address in the next cycle returns the new data.
- Out-of-range access (address >= DEPTH): store ignored, store_count not incremented; load still produces a valid pulse with load_data = 0 and is counted; err set if not already set; err_addr captures the address only when err transitions 0->1. If load and store are both out of range in the same cycle, err_addr takes the store address.
- Memory index = address[clog2(DEPTH)-1:0] after the range check. Upper address bits above the index must be zero for the access to be legal.
- Counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0 without flagging.
- load_data holds its last value between valid pulses. Consumers must not rely on that value.

## Timing
- Reset (rst high at an edge): load_data_valid = 0, all pipeline valid bits = 0, load_data = 0, load_count = 0, store_count = 0, err = 0, err_addr = 0. Memory contents are not cleared.
- Reset is dominant: load_en and store_en in a reset cycle are dropped, with no write and no count.
- Reset mid-read: in-flight loads are discarded, and no valid pulse follows reset.
- READ_LATENCY = 1: load_en at edge N gives load_data_valid and load_data visible in the cycle after edge N. This matches MemCont, which samples data one cycle after issuing a load.
- Counters and err update at the same edge that accepts the request and are visible in the following cycle.

## Test plan
- Reset, then store 0xDEADBEEF at addr 5, load addr 5 next cycle -> load_data_valid pulses 1 cycle after load, load_data = 0xDEADBEEF, store_count = 1, load_count = 1.
- Preload addr 3 = 0x11; same cycle load addr 3 and store 0x22 to addr 3 -> returned data 0x11; load addr 3 again -> 0x22.
- Loads to addrs 0,1,2,3 on consecutive cycles (READ_LATENCY = 3) -> four consecutive valid pulses beginning 3 cycles after the first load, data in order.
- Store to addr DEPTH (1024), then load addr 2000 -> err = 1, err_addr = 1024, store_count unchanged, load returns 0 with valid, load_count = 1.
- Issue load, assert rst the following cycle (READ_LATENCY = 2) -> no valid pulse, counters = 0, previously stored data still readable after reset.
- Force load_count to 0xFFFFFFFF via 2^32-1 loads (or a forced value in sim), then one more load -> load_count = 0, err unchanged.
